// File: rtl/trng_reader.sv
// Consumer-side controller for the TRNG control unit: starts the TRNG, captures
// ready-pulsed words into a show-ahead FIFO and flushes everything on failure.
module trng_reader #(
    parameter int DEPTH       = 4,
    parameter int TIMEOUT_CYC = 2048,
    parameter int DW          = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       start_i,
    input  logic                       stop_i,
    input  logic                       clear_i,
    output logic                       trng_enable_o,
    input  logic                       trng_rnd_ready_i,
    input  logic [DW-1:0]              trng_rnd_data_i,
    output logic                       trng_ack_read_o,
    input  logic                       trng_dead_i,
    output logic                       rd_valid_o,
    input  logic                       rd_ready_i,
    output logic [DW-1:0]              rd_data_o,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count_o,
    output logic                       busy_o,
    output logic                       timeout_o,
    output logic                       fail_o
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [TW-1:0] TMAX_C  = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_WAIT  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_ACK   = 3'd4,
        ST_FAIL  = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            stop_req_q, stop_req_d;
    logic            timeout_q, timeout_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [DW-1:0]   mem_q [DEPTH];
    logic [DW-1:0]   mem_d [DEPTH];
    logic            enable_q, enable_d;
    logic            ack_q, ack_d;
    logic            fail_q, fail_d;
    logic            busy_q, busy_d;
    logic            valid_q, valid_d;
    logic            busy_s;
    logic            push_s;
    logic            pop_s;

    // Next-state selection; a dead TRNG overrides every other event outside IDLE
    always_comb begin
        state_d   = state_q;
        timeout_d = timeout_q;
        if (trng_dead_i && (state_q != ST_IDLE)) begin
            state_d = ST_FAIL;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        state_d = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_START: state_d = ST_WAIT;
                ST_WAIT: begin
                    if (trng_rnd_ready_i) begin
                        state_d = ST_HOLD;
                    end else if (timer_q == TMAX_C) begin
                        state_d   = ST_FAIL;
                        timeout_d = 1'b1;
                    end else if (stop_req_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
                // The TRNG keeps its word until acked, so HOLD may wait forever
                ST_HOLD: begin
                    if (count_q < DEPTH_C) begin
                        state_d = ST_ACK;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end
                ST_ACK: state_d = ST_WAIT;
                ST_FAIL: begin
                    if (clear_i) begin
                        state_d   = ST_IDLE;
                        timeout_d = 1'b0;
                    end else begin
                        state_d = ST_FAIL;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign busy_s = (state_q != ST_IDLE) && (state_q != ST_FAIL);
    assign push_s = (state_q == ST_HOLD) && (count_q < DEPTH_C) && !trng_dead_i;
    assign pop_s  = valid_q && rd_ready_i;

    // Ready timer and stop request bookkeeping
    always_comb begin
        timer_d    = timer_q;
        stop_req_d = stop_req_q;
        if ((state_q == ST_WAIT) && (state_d == ST_WAIT)) begin
            timer_d = timer_q + TW'(1'b1);
        end else begin
            timer_d = {TW{1'b0}};
        end
        if (state_d == ST_IDLE) begin
            stop_req_d = 1'b0;
        end else if (busy_s && stop_i) begin
            stop_req_d = 1'b1;
        end else begin
            stop_req_d = stop_req_q;
        end
    end

    // FIFO pointers, occupancy and storage; any entry into FAIL discards contents
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (state_d == ST_FAIL) begin
            wr_ptr_d = {AW{1'b0}};
            rd_ptr_d = {AW{1'b0}};
            count_d  = {CW{1'b0}};
        end else begin
            if (push_s) begin
                mem_d[wr_ptr_q] = trng_rnd_data_i;
                wr_ptr_d        = wr_ptr_q + AW'(1'b1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + AW'(1'b1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CW'(1'b1);
                2'b01:   count_d = count_q - CW'(1'b1);
                default: count_d = count_q;
            endcase
        end
    end

    // Output flags follow the state being entered so they line up with it
    always_comb begin
        enable_d = (state_d == ST_START);
        ack_d    = (state_d == ST_ACK);
        fail_d   = (state_d == ST_FAIL);
        busy_d   = (state_d != ST_IDLE) && (state_d != ST_FAIL);
        valid_d  = (count_d != {CW{1'b0}});
    end

    // State and datapath registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            timer_q    <= {TW{1'b0}};
            stop_req_q <= 1'b0;
            timeout_q  <= 1'b0;
            wr_ptr_q   <= {AW{1'b0}};
            rd_ptr_q   <= {AW{1'b0}};
            count_q    <= {CW{1'b0}};
            enable_q   <= 1'b0;
            ack_q      <= 1'b0;
            fail_q     <= 1'b0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {DW{1'b0}};
            end
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            stop_req_q <= stop_req_d;
            timeout_q  <= timeout_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            enable_q   <= enable_d;
            ack_q      <= ack_d;
            fail_q     <= fail_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
            mem_q      <= mem_d;
        end
    end

    assign trng_enable_o   = enable_q;
    assign trng_ack_read_o = ack_q;
    assign rd_valid_o      = valid_q;
    assign rd_data_o       = mem_q[rd_ptr_q];
    assign fifo_count_o    = count_q;
    assign busy_o          = busy_q;
    assign timeout_o       = timeout_q;
    assign fail_o          = fail_q;

endmodule

// File: tb/tb_trng_reader.sv
// Directed bench for trng_reader: a behavioural harvesting model is compared
// every cycle, plus literal expectations for each scenario.
module tb_trng_reader;

    localparam int DEPTH       = 4;
    localparam int TIMEOUT_CYC = 2048;
    localparam int DW          = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0, stop = 1'b0, clear = 1'b0;
    logic          rdy = 1'b0, dead = 1'b0, rd_ready = 1'b0;
    logic [DW-1:0] rdata = 32'h0;
    logic          trng_enable_o, trng_ack_read_o, rd_valid_o;
    logic [DW-1:0] rd_data_o;
    logic [2:0]    fifo_count_o;
    logic          busy_o, timeout_o, fail_o;

    int n_checks = 0;
    int n_fail   = 0;

    trng_reader #(.DEPTH(DEPTH), .TIMEOUT_CYC(TIMEOUT_CYC), .DW(DW)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .stop_i(stop), .clear_i(clear),
        .trng_enable_o(trng_enable_o), .trng_rnd_ready_i(rdy), .trng_rnd_data_i(rdata),
        .trng_ack_read_o(trng_ack_read_o), .trng_dead_i(dead),
        .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready), .rd_data_o(rd_data_o),
        .fifo_count_o(fifo_count_o), .busy_o(busy_o), .timeout_o(timeout_o), .fail_o(fail_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: harvesting on/off, a captured-word flag, pending pulses, a word queue
    logic [DW-1:0] m_q[$];
    bit m_on = 0, m_failed = 0, m_en = 0, m_hold = 0, m_ack = 0, m_stop = 0, m_to = 0;
    int m_wait = 0;
    int m_sz;
    bit m_stop_old;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q.delete();
            m_on = 0; m_failed = 0; m_en = 0; m_hold = 0; m_ack = 0;
            m_stop = 0; m_to = 0; m_wait = 0;
        end else begin
            m_sz       = m_q.size();
            m_stop_old = m_stop;
            if (m_sz != 0 && rd_ready) void'(m_q.pop_front());
            if (m_failed) begin
                if (!dead && clear) begin
                    m_failed = 0; m_to = 0; m_stop = 0;
                end
            end else if (m_on && dead) begin
                m_on = 0; m_en = 0; m_hold = 0; m_ack = 0; m_failed = 1;
            end else if (!m_on) begin
                if (start) begin
                    m_on = 1; m_en = 1;
                end
            end else begin
                if (stop) m_stop = 1;
                if (m_en) begin
                    m_en = 0; m_wait = 0;
                end else if (m_hold) begin
                    if (m_sz < DEPTH) begin
                        m_q.push_back(rdata); m_hold = 0; m_ack = 1;
                    end
                end else if (m_ack) begin
                    m_ack = 0; m_wait = 0;
                end else if (rdy) begin
                    m_hold = 1;
                end else if (m_wait == TIMEOUT_CYC - 1) begin
                    m_on = 0; m_failed = 1; m_to = 1;
                end else if (m_stop_old) begin
                    m_on = 0; m_stop = 0;
                end else begin
                    m_wait++;
                end
            end
            if (m_failed) m_q.delete();
        end
    end

    always @(negedge clk) begin
        check("enable", 32'(trng_enable_o), 32'(m_en));
        check("ack", 32'(trng_ack_read_o), 32'(m_ack));
        check("fail", 32'(fail_o), 32'(m_failed));
        check("busy", 32'(busy_o), 32'(m_on));
        check("timeout", 32'(timeout_o), 32'(m_to));
        check("count", 32'(fifo_count_o), 32'(m_q.size()));
        check("valid", 32'(rd_valid_o), 32'(m_q.size() != 0));
        check("count_max", 32'(fifo_count_o <= 3'd4), 32'd1);
        if (m_q.size() != 0) check("rd_data", rd_data_o, m_q[0]);
    end

    logic [DW-1:0] popped[$];
    always @(negedge clk) begin
        if (!rst && rd_valid_o && rd_ready) popped.push_back(rd_data_o);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input int budget);
        int n = 0;
        while (trng_ack_read_o !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check("ack_seen", 32'(trng_ack_read_o), 32'd1);
    endtask

    task automatic send_word(input logic [DW-1:0] d);
        rdata = d;
        rdy   = 1'b1;
        tick();
        rdy   = 1'b0;
        wait_ack(8);
        tick();
    endtask

    task automatic start_harvest;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("enable_pulse", 32'(trng_enable_o), 32'd1);
        tick();
        check("enable_one_cycle", 32'(trng_enable_o), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_enable"}, 32'(trng_enable_o), 32'd0);
        check({tag, "_ack"}, 32'(trng_ack_read_o), 32'd0);
        check({tag, "_valid"}, 32'(rd_valid_o), 32'd0);
        check({tag, "_data"}, rd_data_o, 32'd0);
        check({tag, "_count"}, 32'(fifo_count_o), 32'd0);
        check({tag, "_busy"}, 32'(busy_o), 32'd0);
        check({tag, "_timeout"}, 32'(timeout_o), 32'd0);
        check({tag, "_fail"}, 32'(fail_o), 32'd0);
    endtask

    initial begin
        int n;
        // 1: reset state, first word with two-cycle latency
        repeat (3) tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();
        start_harvest();
        repeat (19) tick();
        rdata = 32'hA5A5_0001;
        rdy   = 1'b1;
        tick();
        rdy   = 1'b0;
        check("t1_hold_no_ack", 32'(trng_ack_read_o), 32'd0);
        check("t1_hold_not_valid", 32'(rd_valid_o), 32'd0);
        tick();
        check("t1_ack", 32'(trng_ack_read_o), 32'd1);
        check("t1_valid", 32'(rd_valid_o), 32'd1);
        check("t1_data", rd_data_o, 32'hA5A5_0001);
        check("t1_count", 32'(fifo_count_o), 32'd1);
        tick();
        check("t1_ack_one_cycle", 32'(trng_ack_read_o), 32'd0);

        // 2: fill to full, fifth word held in HOLD until a pop
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        for (int i = 1; i <= 4; i++) send_word(32'(i));
        check("t2_full", 32'(fifo_count_o), 32'd4);
        rdata = 32'h5;
        rdy   = 1'b1;
        tick();
        rdy   = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("t2_no_ack_full", 32'(trng_ack_read_o), 32'd0);
            check("t2_count_held", 32'(fifo_count_o), 32'd4);
            tick();
        end
        check("t2_head", rd_data_o, 32'h1);
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        check("t2_after_pop", 32'(fifo_count_o), 32'd3);
        wait_ack(4);
        check("t2_refull", 32'(fifo_count_o), 32'd4);
        tick();
        rd_ready = 1'b1;
        for (int i = 2; i <= 5; i++) begin
            check("t2_order", rd_data_o, 32'(i));
            tick();
        end
        rd_ready = 1'b0;
        check("t2_drained", 32'(fifo_count_o), 32'd0);

        // 3: streaming across pointer wrap
        popped.delete();
        for (int i = 0; i < 4; i++) send_word(32'h100 + 32'(i));
        check("t3_full", 32'(fifo_count_o), 32'd4);
        rd_ready = 1'b1;
        for (int i = 4; i < 16; i++) send_word(32'h100 + 32'(i));
        n = 0;
        while (rd_valid_o && n < 10) begin
            tick();
            n++;
        end
        rd_ready = 1'b0;
        check("t3_pop_count", 32'(popped.size()), 32'd16);
        for (int i = 0; i < 16 && i < popped.size(); i++)
            check("t3_stream", popped[i], 32'h100 + 32'(i));

        // 4: ready timeout, flush, clear
        send_word(32'h200);
        send_word(32'h201);
        check("t4_count_before", 32'(fifo_count_o), 32'd2);
        n = 0;
        while (fail_o !== 1'b1 && n < 2100) begin
            tick();
            n++;
        end
        check("t4_timeout_cycles", 32'(n), 32'd2048);
        check("t4_timeout", 32'(timeout_o), 32'd1);
        check("t4_fail", 32'(fail_o), 32'd1);
        check("t4_flushed", 32'(fifo_count_o), 32'd0);
        check("t4_valid", 32'(rd_valid_o), 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t4_start_ignored", 32'(fail_o), 32'd1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("t4_cleared_fail", 32'(fail_o), 32'd0);
        check("t4_cleared_timeout", 32'(timeout_o), 32'd0);
        check("t4_idle", 32'(busy_o), 32'd0);

        // 5: dead in HOLD with two words buffered, dead in IDLE
        start_harvest();
        send_word(32'h300);
        send_word(32'h301);
        rdata = 32'h302;
        rdy   = 1'b1;
        tick();
        rdy   = 1'b0;
        dead  = 1'b1;
        tick();
        check("t5_fail", 32'(fail_o), 32'd1);
        check("t5_no_ack", 32'(trng_ack_read_o), 32'd0);
        check("t5_valid", 32'(rd_valid_o), 32'd0);
        check("t5_flushed", 32'(fifo_count_o), 32'd0);
        dead  = 1'b0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        dead  = 1'b1;
        repeat (3) tick();
        check("t5_idle_dead_fail", 32'(fail_o), 32'd0);
        check("t5_idle_dead_busy", 32'(busy_o), 32'd0);
        dead = 1'b0;

        // 6: stop during HOLD, then reset in the middle of ACK
        start_harvest();
        send_word(32'h600);
        rdata = 32'h601;
        rdy   = 1'b1;
        tick();
        rdy   = 1'b0;
        stop  = 1'b1;
        tick();
        stop  = 1'b0;
        check("t6_ack_completes", 32'(trng_ack_read_o), 32'd1);
        tick();
        check("t6_still_busy", 32'(busy_o), 32'd1);
        tick();
        check("t6_idle", 32'(busy_o), 32'd0);
        check("t6_retained", 32'(fifo_count_o), 32'd2);
        check("t6_head", rd_data_o, 32'h600);
        start_harvest();
        rdata = 32'h602;
        rdy   = 1'b1;
        tick();
        rdy   = 1'b0;
        tick();
        check("t6_in_ack", 32'(trng_ack_read_o), 32'd1);
        rst = 1'b1;
        #1;
        check_all_zero("t6_reset");
        repeat (2) tick();
        rst = 1'b0;
        tick();
        check("t6_after_reset", 32'(fifo_count_o), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
